// File: rtl/vga_timing_driver_pkg.sv
// Shared definitions for the VGA timing driver slice.
// Holds the 640x480@60 default raster constants, the counter type,
// the packed {hs,vs,de} bundle carried down the alignment pipeline,
// and the helper that maps an asserted/deasserted sync term onto the
// board's pin polarity.
package vga_timing_driver_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Default 640x480@60 Hz raster (pixels / lines)
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam logic [11:0] RGB_BLACK = 12'h000;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Pin level for a sync term: pol is the asserted level.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_driver_if.sv
// Pixel request bus between the timing driver and the frame-content block.
//   pixel_xpos/pixel_ypos : requested coordinate (0 outside active area)
//   pixel_req             : coordinate addresses an active pixel
//   pixel_data            : {R,G,B} 4:4:4, returned DATA_LAT cycles later
// master = timing driver, slave = content block.
interface vga_timing_driver_if;
    import vga_timing_driver_pkg::*;

    cnt_t        pixel_xpos;
    cnt_t        pixel_ypos;
    logic        pixel_req;
    logic [11:0] pixel_data;

    modport master (output pixel_xpos, output pixel_ypos, output pixel_req,
                    input  pixel_data);
    modport slave  (input  pixel_xpos, input  pixel_ypos, input  pixel_req,
                    output pixel_data);

endinterface

// File: rtl/vga_timing_driver_delay_line.sv
// vga_delay_line: DEPTH-stage shift register, WIDTH bits wide, with a
// synchronous active-high reset that loads every stage with RST_VAL.
//   clk  : clock
//   rst  : synchronous reset
//   din  : input word
//   dout : din delayed by DEPTH cycles
module vga_delay_line #(
    parameter int                DEPTH   = 1,
    parameter int                WIDTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: raster timing generator for a 4:4:4 VGA connector.
// Runs h/v counters, requests pixels from the content block over the
// pixel bus, delays the raw sync/enable terms by DATA_LAT so they line up
// with the returned pixel_data, then registers the pins once more.
//   clk_25mHz   : pixel clock
//   rst         : synchronous active-high reset
//   pix         : pixel request bus (master side)
//   hs, vs      : sync pins, SYNC_POL is the asserted level
//   vga_r/g/b   : colour pins, forced to 0 during blanking
//   frame_start : one-cycle pulse at raster origin (0,0)
//   v_blank     : high while the line counter is outside the active lines
module vga_timing_driver
    import vga_timing_driver_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   H_ACT    = DEF_H_ACT,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   V_ACT    = DEF_V_ACT,
    parameter int   V_FP     = DEF_V_FP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   DATA_LAT = 1
) (
    input  logic                clk_25mHz,
    input  logic                rst,
    vga_timing_driver_if.master pix,
    output logic                hs,
    output logic                vs,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                frame_start,
    output logic                v_blank
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

    localparam cnt_t H_LAST      = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST      = cnt_t'(V_TOT - 1);
    localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
    localparam cnt_t H_ACT_START = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t V_ACT_START = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACT);
    localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACT);

    cnt_t  h_cnt_p0;
    cnt_t  v_cnt_p0;
    logic  h_act_p0;
    logic  v_act_p0;
    sync_t raw_p0;
    sync_t raw_pd;

    // Stage 0: raster counters and raw timing terms
    always_ff @(posedge clk_25mHz) begin
        if (rst) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + cnt_t'(1);
        end else begin
            h_cnt_p0 <= h_cnt_p0 + cnt_t'(1);
        end
    end

    always_comb begin
        h_act_p0  = (h_cnt_p0 >= H_ACT_START) && (h_cnt_p0 < H_ACT_END);
        v_act_p0  = (v_cnt_p0 >= V_ACT_START) && (v_cnt_p0 < V_ACT_END);
        raw_p0.hs = (h_cnt_p0 < H_SYNC_END);
        raw_p0.vs = (v_cnt_p0 < V_SYNC_END);
        raw_p0.de = h_act_p0 && v_act_p0;
    end

    // Subtractions only reach the bus inside the active window, so the
    // 10-bit wrap below the active start never becomes visible.
    assign pix.pixel_req  = raw_p0.de;
    assign pix.pixel_xpos = raw_p0.de ? (h_cnt_p0 - H_ACT_START) : '0;
    assign pix.pixel_ypos = raw_p0.de ? (v_cnt_p0 - V_ACT_START) : '0;

    assign frame_start = !rst && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    assign v_blank     = !v_act_p0;

    // Stages 1..DATA_LAT: hold sync/enable until pixel_data for the same
    // coordinate returns from the content block
    vga_delay_line #(
        .DEPTH   (DATA_LAT),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_sync_dly (
        .clk  (clk_25mHz),
        .rst  (rst),
        .din  (raw_p0),
        .dout (raw_pd)
    );

    // Output register: pins, RGB blanked whenever the delayed enable is low
    always_ff @(posedge clk_25mHz) begin
        if (rst) begin
            hs                    <= sync_level(1'b0, SYNC_POL);
            vs                    <= sync_level(1'b0, SYNC_POL);
            {vga_r, vga_g, vga_b} <= RGB_BLACK;
        end else begin
            hs                    <= sync_level(raw_pd.hs, SYNC_POL);
            vs                    <= sync_level(raw_pd.vs, SYNC_POL);
            {vga_r, vga_g, vga_b} <= raw_pd.de ? pix.pixel_data : RGB_BLACK;
        end
    end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: one full 640x480 instance (DATA_LAT=1) and
// two reduced-raster instances (DATA_LAT=1 and 3) run side by side, each
// with a registered content block returning {3{xpos[3:0]}} ^ salt for
// requests and random garbage otherwise. Every cycle all outputs are
// compared with a reference computed from the raster rules by arithmetic
// on the cycle count since reset.
module tb_vga_timing_driver;
    import vga_timing_driver_pkg::*;

    typedef struct packed {
        int hs; int hb; int ha; int hf;
        int vs; int vb; int va; int vf;
        int lat;
    } cfg_t;

    localparam cfg_t CFG_A = '{96, 48, 640, 16, 2, 33, 480, 10, 1};
    localparam cfg_t CFG_B = '{3, 2, 8, 2, 2, 2, 4, 2, 1};
    localparam cfg_t CFG_C = '{3, 2, 8, 2, 2, 2, 4, 2, 3};

    logic clk_25mHz = 1'b0;
    logic rst       = 1'b1;
    always #20 clk_25mHz = ~clk_25mHz;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int phase = 0;

    logic [11:0] salt_a, salt_b, salt_c;

    vga_timing_driver_if if_a();
    vga_timing_driver_if if_b();
    vga_timing_driver_if if_c();

    logic       hs_a, vs_a, fs_a, vb_a;
    logic [3:0] r_a, g_a, b_a;
    logic       hs_b, vs_b, fs_b, vb_b;
    logic [3:0] r_b, g_b, b_b;
    logic       hs_c, vs_c, fs_c, vb_c;
    logic [3:0] r_c, g_c, b_c;

    vga_timing_driver #(.DATA_LAT(1)) dut_a (
        .clk_25mHz(clk_25mHz), .rst(rst), .pix(if_a),
        .hs(hs_a), .vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a), .v_blank(vb_a));

    vga_timing_driver #(.H_SYNC(3), .H_BP(2), .H_ACT(8), .H_FP(2),
                        .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
                        .SYNC_POL(1'b0), .DATA_LAT(1)) dut_b (
        .clk_25mHz(clk_25mHz), .rst(rst), .pix(if_b),
        .hs(hs_b), .vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(fs_b), .v_blank(vb_b));

    vga_timing_driver #(.H_SYNC(3), .H_BP(2), .H_ACT(8), .H_FP(2),
                        .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
                        .SYNC_POL(1'b0), .DATA_LAT(3)) dut_c (
        .clk_25mHz(clk_25mHz), .rst(rst), .pix(if_c),
        .hs(hs_c), .vs(vs_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
        .frame_start(fs_c), .v_blank(vb_c));

    // Content blocks: registered lookups, depth equal to each DATA_LAT
    logic [11:0] pd_a, pd_b;
    logic [11:0] pd_c [3];

    always @(posedge clk_25mHz) begin
        pd_a <= if_a.pixel_req ? ({3{if_a.pixel_xpos[3:0]}} ^ salt_a) : 12'($urandom);
        pd_b <= if_b.pixel_req ? ({3{if_b.pixel_xpos[3:0]}} ^ salt_b) : 12'($urandom);
        pd_c[0] <= if_c.pixel_req ? ({3{if_c.pixel_xpos[3:0]}} ^ salt_c) : 12'($urandom);
        pd_c[1] <= pd_c[0];
        pd_c[2] <= pd_c[1];
    end

    assign if_a.pixel_data = pd_a;
    assign if_b.pixel_data = pd_b;
    assign if_c.pixel_data = pd_c[2];

    task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Expected {hs,vs,rgb,req,xpos,ypos,frame_start,v_blank} at cycle tc
    // after the last reset edge; r is the reset level during that cycle.
    function automatic logic [36:0] model(cfg_t c, int tc, logic r, logic [11:0] salt);
        int ht, vt, h, v, u, hu, vu, x, y, xu;
        logic vact, de, deu, hsp, vsp, fs;
        logic [11:0] rgb;
        ht   = c.hs + c.hb + c.ha + c.hf;
        vt   = c.vs + c.vb + c.va + c.vf;
        h    = tc % ht;
        v    = (tc / ht) % vt;
        vact = (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
        de   = vact && (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha);
        x    = de ? h - (c.hs + c.hb) : 0;
        y    = de ? v - (c.vs + c.vb) : 0;
        fs   = (h == 0) && (v == 0) && !r;
        hsp  = 1'b1;
        vsp  = 1'b1;
        rgb  = 12'h000;
        if (tc >= c.lat + 1) begin
            u   = tc - c.lat - 1;
            hu  = u % ht;
            vu  = (u / ht) % vt;
            deu = (vu >= c.vs + c.vb) && (vu < c.vs + c.vb + c.va) &&
                  (hu >= c.hs + c.hb) && (hu < c.hs + c.hb + c.ha);
            xu  = hu - (c.hs + c.hb);
            hsp = !(hu < c.hs);
            vsp = !(vu < c.vs);
            rgb = deu ? ({3{xu[3:0]}} ^ salt) : 12'h000;
        end
        return {hsp, vsp, rgb, de, 10'(x), 10'(y), fs, !vact};
    endfunction

    int hs_low_a = 0;
    int fs_cnt_b = 0;
    int vs_low_b = 0;

    // One clock: the edge consumes the previous reset level, then the
    // new level is applied and all outputs are checked on the falling edge.
    task automatic cycle(input logic r);
        @(posedge clk_25mHz);
        if (rst) t = 0; else t++;
        #1 rst = r;
        @(negedge clk_25mHz);
        chk("pins_a", {hs_a, vs_a, r_a, g_a, b_a, if_a.pixel_req, if_a.pixel_xpos,
                       if_a.pixel_ypos, fs_a, vb_a}, model(CFG_A, t, rst, salt_a));
        chk("pins_b", {hs_b, vs_b, r_b, g_b, b_b, if_b.pixel_req, if_b.pixel_xpos,
                       if_b.pixel_ypos, fs_b, vb_b}, model(CFG_B, t, rst, salt_b));
        chk("pins_c", {hs_c, vs_c, r_c, g_c, b_c, if_c.pixel_req, if_c.pixel_xpos,
                       if_c.pixel_ypos, fs_c, vb_c}, model(CFG_C, t, rst, salt_c));
        if (phase == 0) begin
            if (t >= 1000 && t < 1800 && hs_a == 1'b0) hs_low_a++;
            if (t < 1500 && fs_b) fs_cnt_b++;
            if (t < 1500 && vs_b == 1'b0) vs_low_b++;
            if (t == 1800) chk("hs_low_per_line", 37'(hs_low_a), 37'd96);
            if (t == 1500) chk("frame_start_count", 37'(fs_cnt_b), 37'd10);
            if (t == 1500) chk("vs_low_count", 37'(vs_low_b), 37'd300);
            if (t == 35*800 + 144)
                chk("first_active", {if_a.pixel_req, if_a.pixel_xpos, if_a.pixel_ypos},
                    {1'b1, 10'd0, 10'd0});
            if (t == 35*800 + 783)
                chk("line_end", {if_a.pixel_req, if_a.pixel_xpos, if_a.pixel_ypos},
                    {1'b1, 10'd639, 10'd0});
            if (t == 35*800 + 784)
                chk("front_porch", {if_a.pixel_req, if_a.pixel_xpos, if_a.pixel_ypos},
                    37'd0);
        end
    endtask

    initial begin
        salt_a = 12'($urandom);
        salt_b = 12'($urandom);
        salt_c = 12'($urandom);
        rst = 1'b1;
        repeat (10) cycle(1'b1);
        repeat (29000) cycle(1'b0);
        phase = 1;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 400)) cycle(1'b0);
            cycle(1'b1);
            repeat (600) cycle(1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Issues pixel coordinate requests to the frame-content block (pixel_xpos/pixel_ypos -> pixel_data). Realigns the returned 12-bit pixel_data with delayed hsync/vsync and drives the board's 4:4:4 RGB pins. Also exports frame_start and v_blank so game logic can update sprite state between frames.

Parameters:
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch
V_ACT, 480, active lines
V_FP, 10, vertical front porch
SYNC_POL, 0, asserted level of hs/vs (0 = active-low)
DATA_LAT, 1, clock cycles from coordinate request to valid pixel_data (legal 1..4)

Ports:
clk_25mHz  in  1  pixel clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
pixel_data  in  12  {R[3:0],G[3:0],B[3:0]} from content block, valid DATA_LAT cycles after request
pixel_xpos  out  10  requested column 0..639, 0 outside active
pixel_ypos  out  10  requested row 0..479, 0 outside active
pixel_req  out  1  high when pixel_xpos/pixel_ypos address an active pixel
hs  out  1  horizontal sync to connector
vs  out  1  vertical sync to connector
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
frame_start  out  1  one-cycle pulse at raster origin
v_blank  out  1  high while v_cnt is outside the active lines

Behaviour:
- Counters: h_cnt 0..H_TOT-1 (H_TOT=800) and v_cnt 0..V_TOT-1 (V_TOT=525), both 10 bits.
  - h_cnt increments every cycle and wraps to 0 after H_TOT-1.
  - v_cnt increments only on the h wrap. It wraps to 0 when h_cnt=H_TOT-1 and v_cnt=V_TOT-1 in the same cycle.
- Region order, counting from 0:
  - h: sync 0-95, back porch 96-143, active 144-783, front porch 784-799.
  - v: sync 0-1, back porch 2-34, active 35-514, front porch 515-524.
- Raw terms, combinational from the counters:
  - hs_raw = (h_cnt<H_SYNC).
  - vs_raw = (v_cnt<V_SYNC).
  - de_raw = h active AND v active.
- pixel_req = de_raw.
  - pixel_xpos = h_cnt-(H_SYNC+H_BP) when de_raw, else 0.
  - pixel_ypos = v_cnt-(V_SYNC+V_BP) when de_raw, else 0.
- Alignment pipeline: hs_raw, vs_raw and de_raw each pass through a DATA_LAT-stage shift register. At stage DATA_LAT, pixel_data belongs to the delayed de.
- Output register, one stage:
  - hs <= hs_d ? SYNC_POL : ~SYNC_POL; vs likewise.
  - {vga_r,vga_g,vga_b} <= de_d ? pixel_data : 0.
  - Total latency from counter state to pins is DATA_LAT+1 cycles.
  - Sync-to-RGB relationship at the pins is identical to the raw timing.
- RGB is forced to 0 in every blanking cycle, whatever pixel_data holds.
- frame_start = (h_cnt==0 && v_cnt==0), forced 0 while rst is high. It pulses once per 420000 cycles.
- v_blank = NOT (v active), from the undelayed v_cnt.
- Reset (sync, rst high at a rising edge):
  - h_cnt = v_cnt = 0.
  - All pipeline stages: hs_d = vs_d = de_d = 0.
  - hs = vs = ~SYNC_POL (deasserted); RGB = 0.
  - pixel_req = 0; pixel_xpos = pixel_ypos = 0; frame_start = 0.
  - v_blank = 1 while held, because v_cnt=0 is in the sync region.
- Reset asserted mid-frame aborts the frame. The first cycle after release restarts at (0,0) with frame_start=1, and no partial line is emitted.
- Widths: subtractions are 10-bit and are only evaluated inside the active window, so no underflow is visible.

Decomposition:
- Shared header vga_params.vh holds the timing constants, derived totals and active-start offsets (H_TOT, V_TOT, H_ACT_START=144, V_ACT_START=35) and the colour localparams. The display and driver blocks share it.
- One sub-module, vga_delay_line: parameterised DEPTH/WIDTH shift register with synchronous reset to a parameter value. Instantiated once for {hs,vs,de} (WIDTH=3, DEPTH=DATA_LAT).

Test Plan:
- Reset held 10 cycles, then released, with SYNC_POL=0 -> during reset hs=vs=1, RGB=0, frame_start=0. The first cycle after release shows frame_start=1, h_cnt=0, v_cnt=0.
- Free-run 2 frames -> hs low for exactly 96 of every 800 cycles. vs low for exactly 1600 cycles (2 lines) per 420000. frame_start period is 420000.
- Coordinates: at h_cnt=144, v_cnt=35 -> pixel_req=1, pixel_xpos=0, pixel_ypos=0. At h_cnt=783, v_cnt=514 -> xpos=639, ypos=479. At h_cnt=784 -> pixel_req=0, xpos=0.
- Model content block as registered pixel_data=xpos[3:0] replicated to 12 bits, with DATA_LAT=1 -> pin value at the 2nd cycle after each request equals the request's xpos pattern. RGB=0 in every blanking cycle. Repeat with DATA_LAT=3.
- Drive pixel_data=12'hFFF constantly -> RGB=0 during all 160 horizontal and 45 vertical blanking periods. Exactly 307200 non-zero pixels per frame.
- Assert rst for 1 cycle at h_cnt=400, v_cnt=200 -> next cycle outputs are at reset values. Counting restarts at (0,0) with no RGB until h_cnt=144, v_cnt=35 plus latency.
